fetch_sequencer: RTL

Parametrised program-counter and instruction-fetch sequencer for the mini-MIPS core. It replaces the bare `PC <= PC + 1` / branch update with a state machine that:
- requests instructions from instruction memory over a req/ack handshake;
- presents each fetched PC to decode for one or more cycles;
- resolves register jumps, absolute jumps and relative branches by fixed priority;
- supports stall, halt/resume and an optional branch delay slot.

PCs are word addresses, consistent with the datapath's `PC + 1 + imm` branch arithmetic.

---
 rtl/fetch_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC / instruction-fetch sequencer with req/ack fetch and prioritised redirects.
// Optional branch delay slot enabled by defining BRANCH_DELAY_SLOT_EN.
module fetch_sequencer #(
  parameter int              PC_W     = 32,
  parameter int              IMM_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  output logic [PC_W-1:0]  pc,
  output logic             pc_valid,
  input  logic             stall,
  input  logic             halt,
  input  logic             resume,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [IMM_W-1:0] br_offset,
  input  logic             jmp_valid,
  input  logic [25:0]      jmp_target,
  input  logic             jr_valid,
  input  logic [PC_W-1:0]  jr_target,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] issued
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] issued_q;
  logic             imem_req_q;
  logic             pc_valid_q;

  logic [PC_W-1:0]  pc_plus1;
  logic [PC_W-1:0]  br_off_ext;
  logic [PC_W-1:0]  redirect_target;
  logic             redirect;
  logic [PC_W-1:0]  issue_next_pc;

  generate
    if (IMM_W >= PC_W) begin : g_off_trunc
      assign br_off_ext = br_offset[PC_W-1:0];
    end else begin : g_off_sext
      assign br_off_ext = {{(PC_W-IMM_W){br_offset[IMM_W-1]}}, br_offset};
    end
  endgenerate

  assign pc_plus1 = pc_q + PC_W'(1);

  // Fixed priority: register jump, then absolute jump, then taken branch.
  always_comb begin
    redirect        = 1'b1;
    redirect_target = pc_plus1;
    if (jr_valid)
      redirect_target = jr_target;
    else if (jmp_valid)
      redirect_target = {pc_plus1[PC_W-1:26], jmp_target};
    else if (br_valid && br_taken)
      redirect_target = pc_plus1 + br_off_ext;
    else
      redirect = 1'b0;
  end

`ifdef BRANCH_DELAY_SLOT_EN
  logic [PC_W-1:0] pending_q;
  logic            slot_q;

  assign issue_next_pc = slot_q ? pending_q : pc_plus1;

  // While the delay slot is in ISSUE its own redirect inputs are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      slot_q    <= 1'b0;
    end else if (state_q == S_ISSUE && !stall) begin
      slot_q <= !slot_q && redirect;
      if (!slot_q && redirect)
        pending_q <= redirect_target;
    end
  end
`else
  assign issue_next_pc = redirect ? redirect_target : pc_plus1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      issued_q   <= '0;
      imem_req_q <= 1'b0;
      pc_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q    <= S_FETCH;
          imem_req_q <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            state_q    <= S_ISSUE;
            imem_req_q <= 1'b0;
            pc_valid_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            pc_q       <= issue_next_pc;
            issued_q   <= issued_q + CNT_W'(1);
            pc_valid_q <= 1'b0;
            if (halt) begin
              state_q <= S_HALT;
            end else begin
              state_q    <= S_FETCH;
              imem_req_q <= 1'b1;
            end
          end
        end
        S_HALT: begin
          if (resume) begin
            state_q    <= S_FETCH;
            imem_req_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign pc_valid  = pc_valid_q;
  assign state     = state_q;
  assign issued    = issued_q;

endmodule
